// File: rtl/fifo_buf32.sv
// fifo_buf32 -- 32-entry synchronous FIFO buffer stage.
// Holds the storage array, 6-bit read/write pointers (5 address bits plus a
// wrap bit), decoded occupancy/full/empty flags, and overflow/underflow flags.
// Read data is registered: dout/dout_valid follow the accepted read by one cycle.
// Optional build macro FIFO_STICKY_ERR_EN: when defined, overflow/underflow
// latch until clear; when undefined they are single-cycle pulses.
module fifo_buf32 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic [5:0]        count,
  output logic [5:0]        wr_ptr,
  output logic [5:0]        rd_ptr,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 32;

  // Storage is never reset so it can map onto block/distributed RAM.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [5:0]        wr_ptr_q, wr_ptr_d;
  logic [5:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              full_w, empty_w;
  logic              wr_acc, rd_acc;
  logic              ovf_evt, unf_evt;

  // Flags decoded straight from the registered pointers.
  always_comb begin
    empty_w = (wr_ptr_q == rd_ptr_q);
    full_w  = (wr_ptr_q[4:0] == rd_ptr_q[4:0]) && (wr_ptr_q[5] != rd_ptr_q[5]);
  end

  // Accept decisions and pointer/flag next-state.
  always_comb begin
    rd_acc       = rd_en & ~empty_w;
    // A read on a full FIFO frees a slot in the same edge, so the write may go too.
    wr_acc       = wr_en & (~full_w | rd_acc);
    ovf_evt      = wr_en & full_w & ~rd_acc;
    unf_evt      = rd_en & empty_w;
    wr_ptr_d     = wr_acc ? wr_ptr_q + 6'd1 : wr_ptr_q;
    rd_ptr_d     = rd_acc ? rd_ptr_q + 6'd1 : rd_ptr_q;
    dout_valid_d = rd_acc;
`ifdef FIFO_STICKY_ERR_EN
    overflow_d   = overflow_q | ovf_evt;
    underflow_d  = underflow_q | unf_evt;
`else
    overflow_d   = ovf_evt;
    underflow_d  = unf_evt;
`endif
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[4:0]] <= din;
    end
  end

  // Pointers, registered read data and error flags.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      // A rejected read keeps the last word on dout.
      if (rd_acc) begin
        dout_q <= mem_q[rd_ptr_q[4:0]];
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign count      = wr_ptr_q - rd_ptr_q;
  assign wr_ptr     = wr_ptr_q;
  assign rd_ptr     = rd_ptr_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_buf32.sv
// tb_fifo_buf32 -- self-checking bench for fifo_buf32.
// A queue-based reference model tracks contents, accepted-operation totals and
// expected registered outputs; each test task compares DUT outputs to it.
module tb_fifo_buf32;

  logic       clk = 1'b0;
  logic       clear;
  logic       wr_en, rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid, full, empty, overflow, underflow;
  logic [5:0] count, wr_ptr, rd_ptr;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [7:0] mq[$];
  int         wr_tot, rd_tot;
  logic [7:0] m_dout;
  logic       m_valid, m_ovf, m_unf;

  always #5 clk = ~clk;

  fifo_buf32 #(.DATA_W(8)) dut (
    .clk(clk), .clear(clear), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .count(count), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic model_reset();
    mq.delete();
    wr_tot  = 0;
    rd_tot  = 0;
    m_dout  = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // Drive one clock of stimulus and advance the model (no checking here).
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    int n;
    bit ra, wa, oe, ue;
    wr_en = w;
    rd_en = r;
    din   = d;
    n  = mq.size();
    ra = r && (n > 0);
    wa = w && ((n < 32) || ra);
    oe = w && (n == 32) && !ra;
    ue = r && (n == 0);
    @(posedge clk);
    #1;
    if (ra) begin
      m_dout = mq.pop_front();
      rd_tot++;
    end
    m_valid = ra;
    if (wa) begin
      mq.push_back(d);
      wr_tot++;
    end
`ifdef FIFO_STICKY_ERR_EN
    m_ovf = m_ovf | oe;
    m_unf = m_unf | ue;
`else
    m_ovf = oe;
    m_unf = ue;
`endif
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 clear = 1'b0;
    model_reset();
    @(posedge clk);
    #1 clear = 1'b1;
  endtask

  task automatic test_reset();
    wr_en = 0; rd_en = 0; din = 0;
    clear = 1'b0;
    model_reset();
    #3;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", dout_valid); end
    total++; if (full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0)
      begin bad++; $display("FAIL reset_flags got full=%0b ovf=%0b unf=%0b exp=000", full, overflow, underflow); end
    @(posedge clk);
    #1 clear = 1'b1;
    $display("test_reset: empty=%0b count=%0d", empty, count);
  endtask

  task automatic test_single();
    cycle(1, 0, 8'hA5);
    cycle(0, 1, 8'h00);
    total++; if (dout !== 8'hA5 || dout_valid !== 1'b1)
      begin bad++; $display("FAIL single_read got dout=%h v=%0b exp dout=a5 v=1", dout, dout_valid); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%0b exp=1", empty); end
    cycle(0, 0, 8'h00);
    total++; if (dout_valid !== 1'b0 || dout !== 8'hA5)
      begin bad++; $display("FAIL single_hold got dout=%h v=%0b exp dout=a5 v=0", dout, dout_valid); end
    $display("test_single: dout=%h", dout);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) cycle(1, 0, 8'(i));
    total++; if (full !== 1'b1 || count !== 6'd32)
      begin bad++; $display("FAIL fill_full got full=%0b count=%0d exp full=1 count=32", full, count); end
    cycle(1, 0, 8'hEE);
    total++; if (overflow !== 1'b1 || count !== 6'd32)
      begin bad++; $display("FAIL fill_ovf got ovf=%0b count=%0d exp ovf=1 count=32", overflow, count); end
    for (int i = 0; i < 32; i++) begin
      cycle(0, 1, 8'h00);
      total++; if (dout !== 8'(i) || dout_valid !== 1'b1)
        begin bad++; $display("FAIL fill_drain[%0d] got dout=%h v=%0b exp dout=%h v=1", i, dout, dout_valid, 8'(i)); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_empty got=%0b exp=1", empty); end
    $display("test_fill: drained, empty=%0b", empty);
  endtask

  task automatic test_read_full();
    logic [7:0] last;
    for (int i = 0; i < 32; i++) cycle(1, 0, 8'(8'h40 + i));
    cycle(1, 1, 8'h77);
    total++; if (count !== 6'd32 || overflow !== 1'b0 || dout !== 8'h40)
      begin bad++; $display("FAIL rdfull got count=%0d ovf=%0b dout=%h exp count=32 ovf=0 dout=40", count, overflow, dout); end
    last = 8'h00;
    for (int i = 0; i < 32; i++) begin
      cycle(0, 1, 8'h00);
      last = dout;
    end
    total++; if (last !== 8'h77 || empty !== 1'b1)
      begin bad++; $display("FAIL rdfull_last got dout=%h empty=%0b exp dout=77 empty=1", last, empty); end
    $display("test_read_full: last=%h", last);
  endtask

  task automatic test_read_empty();
    cycle(1, 1, 8'h3C);
    total++; if (underflow !== 1'b1 || dout_valid !== 1'b0 || count !== 6'd1)
      begin bad++; $display("FAIL rdempty got unf=%0b v=%0b count=%0d exp unf=1 v=0 count=1", underflow, dout_valid, count); end
    cycle(0, 1, 8'h00);
    total++; if (dout !== 8'h3C || dout_valid !== 1'b1)
      begin bad++; $display("FAIL rdempty_next got dout=%h v=%0b exp dout=3c v=1", dout, dout_valid); end
    total++; if (underflow !== m_unf)
      begin bad++; $display("FAIL rdempty_unf got=%0b exp=%0b", underflow, m_unf); end
    $display("test_read_empty: dout=%h", dout);
  endtask

  task automatic test_wrap();
    bit saw_full;
    do_reset();
    saw_full = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1, 0, 8'($urandom));
      if (full) saw_full = 1;
      cycle(0, 1, 8'h00);
      total++; if (dout !== m_dout || dout_valid !== 1'b1)
        begin bad++; $display("FAIL wrap_data[%0d] got dout=%h v=%0b exp dout=%h v=1", i, dout, dout_valid, m_dout); end
    end
    total++; if (wr_ptr !== 6'd36 || rd_ptr !== 6'd36)
      begin bad++; $display("FAIL wrap_ptr got wr=%0d rd=%0d exp 36/36", wr_ptr, rd_ptr); end
    total++; if (saw_full) begin bad++; $display("FAIL wrap_full got=1 exp=0"); end
    $display("test_wrap: wr_ptr=%0d rd_ptr=%0d", wr_ptr, rd_ptr);
  endtask

  task automatic test_random();
    int wbias;
    for (int i = 0; i < 600; i++) begin
      // Alternate write-heavy and read-heavy phases to reach both ends.
      wbias = ((i / 100) % 2 == 0) ? 80 : 25;
      cycle(($urandom_range(99) < wbias), ($urandom_range(99) < (100 - wbias)), 8'($urandom));
      total++;
      if (count !== 6'(mq.size()) || full !== (mq.size() == 32) || empty !== (mq.size() == 0) ||
          wr_ptr !== 6'(wr_tot) || rd_ptr !== 6'(rd_tot) || dout_valid !== m_valid ||
          dout !== m_dout || overflow !== m_ovf || underflow !== m_unf) begin
        bad++;
        $display("FAIL random[%0d] got cnt=%0d f=%0b e=%0b wp=%0d rp=%0d v=%0b d=%h o=%0b u=%0b exp cnt=%0d wp=%0d rp=%0d v=%0b d=%h o=%0b u=%0b",
                 i, count, full, empty, wr_ptr, rd_ptr, dout_valid, dout, overflow, underflow,
                 mq.size(), 6'(wr_tot), 6'(rd_tot), m_valid, m_dout, m_ovf, m_unf);
      end
    end
    $display("test_random: 600 cycles, final count=%0d", count);
  endtask

  task automatic test_mid_reset();
    do_reset();
    cycle(0, 1, 8'h00);              // underflow event
    for (int i = 0; i < 10; i++) cycle(1, 0, 8'(i));
    total++; if (count !== 6'd10) begin bad++; $display("FAIL midrst_pre got count=%0d exp=10", count); end
    // Assert clear mid-cycle with an operation pending.
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h99;
    #2 clear = 1'b0;
    model_reset();
    #1;
    total++; if (count !== 6'd0 || wr_ptr !== 6'd0 || rd_ptr !== 6'd0 || empty !== 1'b1)
      begin bad++; $display("FAIL midrst got count=%0d wp=%0d rp=%0d e=%0b exp 0/0/0/1", count, wr_ptr, rd_ptr, empty); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0 || dout_valid !== 1'b0)
      begin bad++; $display("FAIL midrst_flags got o=%0b u=%0b v=%0b exp 000", overflow, underflow, dout_valid); end
    @(posedge clk);
    #1;
    total++; if (count !== 6'd0) begin bad++; $display("FAIL midrst_hold got count=%0d exp=0", count); end
    wr_en = 1'b0; rd_en = 1'b0;
    clear = 1'b1;
    $display("test_mid_reset: count=%0d empty=%0b", count, empty);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_read_full();
    test_read_empty();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
